// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
//   Operand/function/flag bus between the multiply sequencer (master) and the
//   ALU (slave).
//   ALU_A, ALU_B  : 32-bit operands, driven by the master
//   ALU_FunSel    : 5-bit function select, driven by the master
//   ALU_WF        : flag write enable, driven by the master
//   ALU_Out       : combinational ALU result, driven by the slave
//   ALU_Flags     : registered {Z,C,N,O}, driven by the slave
interface alu_mul_sequencer_if;
   logic [31:0] ALU_A;
   logic [31:0] ALU_B;
   logic [4:0]  ALU_FunSel;
   logic        ALU_WF;
   logic [31:0] ALU_Out;
   logic [3:0]  ALU_Flags;

   modport master (
      output ALU_A, ALU_B, ALU_FunSel, ALU_WF,
      input  ALU_Out, ALU_Flags
   );

   modport slave (
      input  ALU_A, ALU_B, ALU_FunSel, ALU_WF,
      output ALU_Out, ALU_Flags
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Unsigned WIDTH x WIDTH shift-and-add multiplier that borrows the ALU's
//   32-bit adder for every partial-product add, then issues one flag-write
//   pass so the ALU's Z/N flags describe the product.
//   Clock, Reset  : system clock, synchronous active-high reset
//   Start         : request, accepted in IDLE or DONE
//   Multiplicand  : WIDTH-bit operand, sampled on the accepting edge
//   Multiplier    : WIDTH-bit operand, sampled on the accepting edge
//   Busy          : high in ITER and FLAG
//   Done          : one-cycle pulse in DONE
//   Product       : 32-bit zero-extended product, held until next Start
//   Zero          : product-zero from the ALU Z flag
//   alu           : ALU operand/function/flag bus (master side)
module alu_mul_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Start,
   input  logic [WIDTH-1:0]    Multiplicand,
   input  logic [WIDTH-1:0]    Multiplier,
   output logic                Busy,
   output logic                Done,
   output logic [31:0]         Product,
   output logic                Zero,
   alu_mul_sequencer_if.master alu
);

   localparam logic [4:0] FS_ADD   = 5'b10100;
   localparam logic [4:0] FS_PASS  = 5'b10000;
   localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ITER, FLAG, DONE} state_e;

   state_e           state_q, state_d;
   logic [31:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [31:0]      acc_q, acc_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             accept;

   // C/N/O are never consulted: no overflow is possible for WIDTH <= 16.
   logic unused_flags;
   assign unused_flags = ^alu.ALU_Flags[2:0];

   assign accept = Start && (state_q == IDLE || state_q == DONE);

   // ---- state register ----
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         zero_q   <= zero_d;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Start) state_d = ITER;
         ITER:    if (cnt_q == CNT_LAST) state_d = FLAG;
         FLAG:    state_d = DONE;
         DONE:    state_d = Start ? ITER : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- datapath next values ----
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      zero_d   = zero_q;
      if (accept) begin
         mcand_d  = 32'(Multiplicand);
         mplier_d = Multiplier;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (state_q == ITER) begin
         // ALU_Out is the add of acc and mcand issued this same cycle.
         if (mplier_q[0]) acc_d = alu.ALU_Out;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 5'd1;
      end
      // Flags were written at the FLAG edge; keep Z for after DONE.
      if (state_q == DONE) zero_d = alu.ALU_Flags[3];
   end

   // ---- outputs ----
   always_comb begin
      Busy           = 1'b0;
      Done           = 1'b0;
      Product        = acc_q;
      Zero           = zero_q;
      alu.ALU_A      = '0;
      alu.ALU_B      = '0;
      alu.ALU_FunSel = FS_PASS;
      alu.ALU_WF     = 1'b0;
      case (state_q)
         ITER: begin
            Busy      = 1'b1;
            alu.ALU_A = acc_q;
            if (mplier_q[0]) begin
               alu.ALU_B      = mcand_q;
               alu.ALU_FunSel = FS_ADD;
            end
         end
         FLAG: begin
            Busy       = 1'b1;
            alu.ALU_A  = acc_q;
            alu.ALU_WF = 1'b1;
         end
         DONE: begin
            Done = 1'b1;
            Zero = alu.ALU_Flags[3];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
//   Directed bench for alu_mul_sequencer (WIDTH=16) with a behavioural ALU
//   attached to the slave side of the bus.
module tb_alu_mul_sequencer;
   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [15:0] Multiplicand;
   logic [15:0] Multiplier;
   logic        Busy;
   logic        Done;
   logic [31:0] Product;
   logic        Zero;

   int total = 0;
   int bad   = 0;

   alu_mul_sequencer_if alu_if ();

   alu_mul_sequencer #(.WIDTH(16)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Start        (Start),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Busy         (Busy),
      .Done         (Done),
      .Product      (Product),
      .Zero         (Zero),
      .alu          (alu_if.master)
   );

   always #5 Clock = ~Clock;

   // Behavioural ALU: combinational result, flags {Z,C,N,O} latched on WF.
   always_comb begin
      if (alu_if.ALU_FunSel == 5'b10100) alu_if.ALU_Out = alu_if.ALU_A + alu_if.ALU_B;
      else                               alu_if.ALU_Out = alu_if.ALU_A;
   end

   always_ff @(posedge Clock) begin
      if (Reset)              alu_if.ALU_Flags <= 4'b0000;
      else if (alu_if.ALU_WF) alu_if.ALU_Flags <= {alu_if.ALU_Out == 32'd0, 1'b0, alu_if.ALU_Out[31], 1'b0};
   end

   task automatic tick();
      @(negedge Clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one operation and follow it to its Done (or a 40-cycle bound).
   // Cycle 1 is the first cycle after the accepting edge. Start is re-driven
   // with hmc/hmp during cycles hs..he to probe that it is ignored.
   task automatic run(input logic [15:0] mc, input logic [15:0] mp,
                      input int hs, input int he,
                      input logic [15:0] hmc, input logic [15:0] hmp,
                      output int done_cyc, output int wf_cnt,
                      output int wf_cyc, output int busy_bad);
      int cyc;
      Multiplicand = mc;
      Multiplier   = mp;
      Start        = 1'b1;
      tick();
      cyc      = 1;
      done_cyc = -1;
      wf_cnt   = 0;
      wf_cyc   = -1;
      busy_bad = 0;
      while (cyc <= 40) begin
         Start = (cyc >= hs && cyc <= he);
         if (Start) begin
            Multiplicand = hmc;
            Multiplier   = hmp;
         end
         if (alu_if.ALU_WF) begin
            wf_cnt++;
            wf_cyc = cyc;
         end
         if (Busy !== (cyc <= 17)) busy_bad++;
         if (Done) begin
            done_cyc = cyc;
            break;
         end
         tick();
         cyc++;
      end
      Start = 1'b0;
   endtask

   initial begin
      int dc, wc, wcy, bb, ndone;

      Reset        = 1'b1;
      Start        = 1'b0;
      Multiplicand = '0;
      Multiplier   = '0;
      tick();
      tick();
      chk("rst_busy",   32'(Busy), 32'd0);
      chk("rst_done",   32'(Done), 32'd0);
      chk("rst_prod",   Product, 32'd0);
      chk("rst_zero",   32'(Zero), 32'd0);
      chk("rst_alu_a",  alu_if.ALU_A, 32'd0);
      chk("rst_alu_b",  alu_if.ALU_B, 32'd0);
      chk("rst_funsel", 32'(alu_if.ALU_FunSel), 32'h10);
      chk("rst_wf",     32'(alu_if.ALU_WF), 32'd0);
      Reset = 1'b0;
      tick();

      // 3 x 5
      run(16'd3, 16'd5, 0, -1, 16'd0, 16'd0, dc, wc, wcy, bb);
      chk("m35_done_cyc", 32'(dc), 32'd18);
      chk("m35_prod",     Product, 32'h0000000F);
      chk("m35_zero",     32'(Zero), 32'd0);
      chk("m35_wf_cnt",   32'(wc), 32'd1);
      chk("m35_wf_cyc",   32'(wcy), 32'd17);
      chk("m35_busy",     32'(bb), 32'd0);
      tick();

      // 0xFFFF x 0xFFFF
      run(16'hFFFF, 16'hFFFF, 0, -1, 16'd0, 16'd0, dc, wc, wcy, bb);
      chk("mff_done_cyc", 32'(dc), 32'd18);
      chk("mff_prod",     Product, 32'hFFFE0001);
      chk("mff_zero",     32'(Zero), 32'd0);
      chk("mff_nflag",    32'(alu_if.ALU_Flags[1]), 32'd1);
      tick();

      // 0 x 0x1234
      run(16'h0000, 16'h1234, 0, -1, 16'd0, 16'd0, dc, wc, wcy, bb);
      chk("m0_done_cyc",  32'(dc), 32'd18);
      chk("m0_prod",      Product, 32'd0);
      chk("m0_zero_done", 32'(Zero), 32'd1);
      chk("m0_wf_cnt",    32'(wc), 32'd1);
      tick();
      chk("m0_zero_held", 32'(Zero), 32'd1);
      chk("m0_done_low",  32'(Done), 32'd0);

      // 3 x 5 with Start held high (7 x 7) in cycles 2..10
      run(16'd3, 16'd5, 2, 10, 16'd7, 16'd7, dc, wc, wcy, bb);
      chk("hold_done_cyc", 32'(dc), 32'd18);
      chk("hold_prod",     Product, 32'h0000000F);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (Done) ndone++;
      end
      chk("hold_extra_done", 32'(ndone), 32'd0);
      chk("hold_prod_after", Product, 32'h0000000F);

      // Reset during cycle 8 of 0x1234 x 0x0010
      Multiplicand = 16'h1234;
      Multiplier   = 16'h0010;
      Start        = 1'b1;
      tick();
      Start = 1'b0;
      repeat (7) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_prod", Product, 32'd0);
      chk("abort_wf",   32'(alu_if.ALU_WF), 32'd0);
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         if (Done) ndone++;
         tick();
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      run(16'd2, 16'd2, 0, -1, 16'd0, 16'd0, dc, wc, wcy, bb);
      chk("m22_done_cyc", 32'(dc), 32'd18);
      chk("m22_prod",     Product, 32'd4);

      // Back-to-back: 3 x 5, then 6 x 7 started in the DONE cycle
      tick();
      run(16'd3, 16'd5, 0, -1, 16'd0, 16'd0, dc, wc, wcy, bb);
      chk("b2b1_done_cyc", 32'(dc), 32'd18);
      chk("b2b1_prod",     Product, 32'h0000000F);
      run(16'd6, 16'd7, 0, -1, 16'd0, 16'd0, dc, wc, wcy, bb);
      chk("b2b2_done_cyc", 32'(dc), 32'd18);
      chk("b2b2_prod",     Product, 32'h0000002A);
      chk("b2b2_busy",     32'(bb), 32'd0);
      chk("b2b2_wf_cnt",   32'(wc), 32'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle unsigned multiply sequencer that acts as the initiator on the ALU's operand/FunSel/WF/flags interface. It performs a WIDTH×WIDTH shift-and-add multiply, issuing each partial-product addition to the ALU as a 32-bit A+B operation and capturing ALUOut. On the last step it issues a flag-write pass so the ALU's Z/N flags reflect the product. It sits between the control unit (Start/Done) and the ALU.

## Interface
- WIDTH, 16, operand width; legal 1..16; product width is 2*WIDTH, zero-extended to 32 bits.
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; accepted only in IDLE or DONE.
- Multiplicand  in  WIDTH  operand, sampled on the accepting edge.
- Multiplier  in  WIDTH  operand, sampled on the accepting edge.
- Busy  out  1  high in ITER and FLAG.
- Done  out  1  one-cycle pulse in DONE.
- Product  out  32  result; valid from DONE; held until the next accepted Start.
- Zero  out  1  product-zero indication taken from the ALU Z flag.
- ALU_A  out  32  ALU operand A.
- ALU_B  out  32  ALU operand B.
- ALU_FunSel  out  5  ALU function: bit4=1 (32-bit); 5'b10100 = A+B, 5'b10000 = pass A.
- ALU_WF  out  1  ALU flag write enable.
- ALU_Out  in  32  combinational ALU result.
- ALU_Flags  in  4  registered ALU flags {Z,C,N,O} at bits [3:0] (Z=bit3).

## Operation
- States: IDLE, ITER, FLAG, DONE. Reset forces IDLE from any state.
- Internal registers:
  - mcand (32 bits, shifted left)
  - mplier (WIDTH bits, shifted right)
  - acc (32 bits)
  - cnt (5 bits)
  - zero_q
- Accepting Start (in IDLE or DONE):
  - mcand <= zero-extended Multiplicand; mplier <= Multiplier; acc <= 0; cnt <= 0.
  - Next state ITER.
- ITER, one step per cycle:
  - mplier[0]=1: drive ALU_A=acc, ALU_B=mcand, ALU_FunSel=5'b10100; acc <= ALU_Out.
  - mplier[0]=0: drive pass A (5'b10000); acc unchanged.
  - Every step: mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - When cnt==WIDTH-1, next state FLAG.
  - ALU_WF=0 throughout ITER.
- FLAG:
  - Drive ALU_A=acc, ALU_B=0, ALU_FunSel=5'b10000, ALU_WF=1 for exactly this cycle.
  - The ALU latches Z/N from acc at this edge. Next state DONE.
- DONE:
  - Done=1.
  - Zero = ALU_Flags[3] combinationally; zero_q <= ALU_Flags[3].
  - Next state IDLE, or ITER if Start=1.
- Zero output: ALU_Flags[3] while in DONE, zero_q otherwise.
- Product = acc.
- Idle ALU drive (IDLE and DONE): ALU_A=0, ALU_B=0, ALU_FunSel=5'b10000, ALU_WF=0.
- Arithmetic: every addition is 32-bit unsigned. WIDTH≤16 guarantees no overflow, so the ALU C/O flags are ignored.
- Start in ITER or FLAG is ignored and operands are not resampled.

## Timing
- Reset values:
  - Outputs: Busy=0, Done=0, Product=0, Zero=0, ALU_A=0, ALU_B=0, ALU_FunSel=5'b10000, ALU_WF=0.
  - Internal: state=IDLE, cnt=0, zero_q=0.
- Latency: Start accepted at edge 0.
  - ITER occupies cycles 1..WIDTH.
  - FLAG occupies cycle WIDTH+1.
  - Done is high in cycle WIDTH+2 (cycle 18 for WIDTH=16).
- Fixed latency, independent of operand values.
- Throughput: Start during DONE gives back-to-back operations, so the next ITER begins in the cycle after DONE, with no IDLE cycle.
- ALU_WF asserts exactly once per operation, in FLAG.
- Reset asserted mid-operation:
  - Returns to IDLE at that edge; Done is not asserted for the aborted operation.
  - Product reads 0.
  - ALU_WF is 0 from the next cycle.
- ALU paths are combinational; the sequencer samples ALU_Out at the same edge at which it drives the operands.

## Test plan
- 3×5 (WIDTH=16): Done pulses in cycle 18 after Start; Product=0x0000000F; Zero=0; ALU_WF high only in cycle 17.
- 0xFFFF×0xFFFF: Product=0xFFFE0001; Zero=0; ALU N flag=1 after FLAG.
- 0x0000×0x1234: Product=0; Zero=1 in DONE and held afterward; exactly one ALU_WF pulse.
- Start held high from cycle 2 to cycle 10 with new operands 7×7 while running 3×5: Product=0x0000000F; Done occurs once.
- Reset in cycle 8 of 0x1234×0x0010: IDLE next cycle; Product=0; no Done; a following 2×2 gives Product=4 at the normal latency.
- Start asserted during DONE of 3×5 with 6×7: the second Done comes 18 cycles after the first DONE cycle; Product=0x0000002A.
